// File: rtl/tmds_decode.sv
// TMDS receive decoder: 10b symbol -> 8b pixel / c0 / c1 / de, with a bitslip word-alignment FSM.
// Optional running-disparity monitor, built only when DISPARITY_CHECK_EN is defined.
module tmds_decode #(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int SLIP_WAIT      = 16,
  parameter int LOSS_TIMEOUT   = 4096,
  parameter int DISP_LIMIT     = 20
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic [9:0] symbol_in,
  output logic [7:0] data_out,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       bitslip,
  output logic       aligned,
  output logic       disp_err
);
  localparam int RW = $clog2(CTRL_RUN) + 1;
  localparam int TW = $clog2(SEARCH_TIMEOUT) + 1;
  localparam int WW = $clog2(SLIP_WAIT) + 1;
  localparam int LW = $clog2(LOSS_TIMEOUT) + 1;
  localparam logic [RW-1:0] RUN_LAST  = RW'(CTRL_RUN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(SEARCH_TIMEOUT - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(SLIP_WAIT - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_TIMEOUT - 1);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_SLIP   = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_LOCKED = 2'd3;

  // The disparity accumulator is 7-bit signed; one more symbol (+/-10) must still fit.
  if (DISP_LIMIT < 0 || DISP_LIMIT > 53) begin : g_bad_limit
    $error("DISP_LIMIT out of range for 7-bit accumulator");
  end

  logic       w_in_ctrl;
  logic [1:0] w_in_cbits;
  logic [9:0] r_sym;
  logic       r_ctrl;
  logic [1:0] r_cbits;
  logic [7:0] w_d, w_data;

  always_comb begin
    w_in_ctrl  = 1'b1;
    w_in_cbits = 2'b00;
    case (symbol_in)
      10'h0AB: w_in_cbits = 2'b00;
      10'h354: w_in_cbits = 2'b01;
      10'h0AA: w_in_cbits = 2'b10;
      10'h355: w_in_cbits = 2'b11;
      default: w_in_ctrl  = 1'b0;
    endcase
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sym   <= '0;
      r_ctrl  <= 1'b0;
      r_cbits <= 2'b00;
    end else begin
      r_sym   <= symbol_in;
      r_ctrl  <= w_in_ctrl;
      r_cbits <= w_in_cbits;
    end
  end

  always_comb begin
    w_d    = r_sym[9] ? ~r_sym[7:0] : r_sym[7:0];
    w_data = '0;
    w_data[0] = w_d[0];
    for (int i = 1; i < 8; i++)
      w_data[i] = r_sym[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
  end

  logic [1:0]    r_state, w_state_nx;
  logic [RW-1:0] r_run;
  logic [TW-1:0] r_to;
  logic [WW-1:0] r_wait;
  logic [LW-1:0] r_loss;
  logic          w_al_nx;

  // A control token in the same cycle as a loss timeout keeps lock (checked via !r_ctrl).
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_SEARCH: if (r_ctrl && r_run == RUN_LAST)      w_state_nx = S_LOCKED;
                else if (!r_ctrl && r_to == TO_LAST)  w_state_nx = S_SLIP;
      S_SLIP:   w_state_nx = S_WAIT;
      S_WAIT:   if (r_wait == WAIT_LAST)              w_state_nx = S_SEARCH;
      S_LOCKED: if (!r_ctrl && r_loss == LOSS_LAST)   w_state_nx = S_SEARCH;
      default:  w_state_nx = S_SEARCH;
    endcase
  end
  assign w_al_nx = (w_state_nx == S_LOCKED);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_SEARCH;
      r_run   <= '0;
      r_to    <= '0;
      r_wait  <= '0;
      r_loss  <= '0;
    end else begin
      r_state <= w_state_nx;
      case (r_state)
        S_SEARCH: begin
          if (w_state_nx != S_SEARCH) begin
            r_run <= '0;
            r_to  <= '0;
          end else if (r_ctrl) begin
            r_run <= (r_run == '1) ? r_run : r_run + 1'b1;
            r_to  <= '0;
          end else begin
            r_run <= '0;
            r_to  <= (r_to == '1) ? r_to : r_to + 1'b1;
          end
        end
        S_WAIT:
          r_wait <= (w_state_nx != S_WAIT || r_wait == '1) ? '0 : r_wait + 1'b1;
        S_LOCKED:
          r_loss <= (r_ctrl || w_state_nx != S_LOCKED || r_loss == '1) ? '0 : r_loss + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data_out <= '0;
      hsync    <= 1'b0;
      vsync    <= 1'b0;
      de       <= 1'b0;
      bitslip  <= 1'b0;
      aligned  <= 1'b0;
    end else begin
      bitslip <= (w_state_nx == S_SLIP);
      aligned <= w_al_nx;
      if (!w_al_nx) begin
        data_out <= '0;
        de       <= 1'b0;
        hsync    <= 1'b0;
        vsync    <= 1'b0;
      end else if (r_ctrl) begin
        data_out <= '0;
        de       <= 1'b0;
        {vsync, hsync} <= r_cbits;
      end else begin
        data_out <= w_data;
        de       <= 1'b1;
      end
    end
  end

`ifdef DISPARITY_CHECK_EN
  localparam logic signed [6:0] DLIM = 7'(DISP_LIMIT);
  logic signed [6:0] r_disp, w_bal, w_sum, w_mag;
  logic [3:0]        w_ones;
  logic              w_viol;

  always_comb begin
    w_ones = '0;
    for (int i = 0; i < 10; i++) w_ones = w_ones + {3'b000, r_sym[i]};
    w_bal  = $signed({2'b00, w_ones, 1'b0}) - 7'sd10;
    w_sum  = r_disp + w_bal;
    w_mag  = (w_sum < 0) ? -w_sum : w_sum;
    w_viol = w_al_nx && !r_ctrl && (w_mag > DLIM);
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_disp   <= '0;
      disp_err <= 1'b0;
    end else begin
      disp_err <= w_viol;
      if (r_ctrl || !w_al_nx || w_viol) r_disp <= '0;
      else                              r_disp <= w_sum;
    end
  end
`else
  assign disp_err = 1'b0;
`endif

endmodule

// File: tb/tb_tmds_decode.sv
// Scoreboard bench for tmds_decode: a reference TMDS encoder feeds random bytes, directed
// phases cover lock acquisition, loss of lock, bitslip timing, disparity and async reset.
module tb_tmds_decode;
`ifdef DISPARITY_CHECK_EN
  localparam bit DISP_ON = 1'b1;
`else
  localparam bit DISP_ON = 1'b0;
`endif
  localparam int T_SEARCH = 1024;
  localparam int T_WAIT   = 16;
  localparam logic CD0 = !DISP_ON;

  logic       vga_clk, sys_rst_n;
  logic [9:0] symbol_in;
  logic [7:0] data_out;
  logic       hsync, vsync, de, bitslip, aligned, disp_err;

  tmds_decode dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .symbol_in(symbol_in),
    .data_out(data_out), .hsync(hsync), .vsync(vsync), .de(de),
    .bitslip(bitslip), .aligned(aligned), .disp_err(disp_err)
  );

  typedef struct {
    int         due;
    logic [7:0] d;
    logic       de, hs, vs, al, derr, cd;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         pulses[$];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         enc_cnt = 0;
  logic       m_hs = 1'b0, m_vs = 1'b0;
  logic [9:0] toks [4] = '{10'h0AB, 10'h354, 10'h0AA, 10'h355};

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  always @(negedge vga_clk)
    if (sys_rst_n && bitslip) pulses.push_back(cyc);

  always @(negedge vga_clk) begin
    if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      vectors++;
      if (mon_e.due != cyc || data_out !== mon_e.d || de !== mon_e.de || hsync !== mon_e.hs ||
          vsync !== mon_e.vs || aligned !== mon_e.al || (mon_e.cd && disp_err !== mon_e.derr)) begin
        miscompares++;
        $display("FAIL out@%0d (due %0d): got d=%h de=%b hs=%b vs=%b al=%b derr=%b, expected d=%h de=%b hs=%b vs=%b al=%b derr=%b",
                 cyc, mon_e.due, data_out, de, hsync, vsync, aligned, disp_err,
                 mon_e.d, mon_e.de, mon_e.hs, mon_e.vs, mon_e.al, mon_e.derr);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Apply one symbol and queue what should appear two clocks later.
  task automatic drive(input logic [9:0] s, input logic al, input logic [7:0] byt,
                       input logic cd, input logic xd);
    exp_t e;
    logic c;
    c = 1'b0;
    for (int i = 0; i < 4; i++)
      if (s == toks[i]) begin
        c = 1'b1;
        {m_vs, m_hs} = 2'(i);
      end
    @(negedge vga_clk);
    symbol_in = s;
    e.due  = cyc + 2;
    e.al   = al;
    e.de   = al && !c;
    e.d    = (al && !c) ? byt : 8'h00;
    e.hs   = al && m_hs;
    e.vs   = al && m_vs;
    e.derr = xd;
    e.cd   = cd;
    exp_q.push_back(e);
  endtask

  // Reference DVI TMDS encoder with running disparity.
  task automatic enc(input logic [7:0] d, output logic [9:0] q);
    logic [8:0] qm;
    int n1, n1q, n0q;
    n1 = $countones(d);
    qm = '0;
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && !d[0])) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_cnt == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      enc_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt += 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_cnt += -2 * int'(!qm[8]) + n1q - n0q;
    end
  endtask

  task automatic do_reset();
    repeat (3) @(negedge vga_clk);
    sys_rst_n = 1'b0;
    symbol_in = 10'h100;
    exp_q.delete();
    repeat (2) @(negedge vga_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic acquire_lock();
    for (int i = 0; i < 8; i++) drive(10'h0AB, i == 7, 8'h00, CD0, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    logic [9:0] q;
    int run, rel;
    sys_rst_n = 1'b0;
    symbol_in = 10'h100;
    #12;
    chk("rst_data", int'(data_out), 0);
    chk("rst_hsync", int'(hsync), 0);
    chk("rst_vsync", int'(vsync), 0);
    chk("rst_de", int'(de), 0);
    chk("rst_bitslip", int'(bitslip), 0);
    chk("rst_aligned", int'(aligned), 0);
    chk("rst_disp_err", int'(disp_err), 0);
    @(negedge vga_clk);
    sys_rst_n = 1'b1;

    acquire_lock();
    drive(10'h100, 1'b1, 8'h00, CD0, 1'b0);
    drive(10'h200, 1'b1, 8'hFF, CD0, 1'b0);
    drive(10'h355, 1'b1, 8'h00, CD0, 1'b0);

    run = 0;
    for (int n = 0; n < 10000; n++) begin
      if (n == 9999 || run >= 200 || $urandom_range(0, 63) == 0) begin
        drive(toks[$urandom_range(0, 3)], 1'b1, 8'h00, CD0, 1'b0);
        enc_cnt = 0;
        run = 0;
      end else begin
        b = 8'($urandom);
        enc(b, q);
        drive(q, 1'b1, b, CD0, 1'b0);
        run++;
      end
    end

    drive(10'h0AB, 1'b1, 8'h00, CD0, 1'b0);
    for (int k = 1; k < 4096; k++) drive(10'h100, 1'b1, 8'h00, CD0, 1'b0);
    drive(10'h0AB, 1'b1, 8'h00, CD0, 1'b0);
    for (int k = 1; k <= 4096; k++) drive(10'h100, k < 4096, 8'h00, CD0, 1'b0);
    repeat (3) @(negedge vga_clk);
    chk("no_slip_while_locking", pulses.size(), 0);

    do_reset();
    rel = cyc;
    pulses.delete();
    for (int k = 0; k < 2100; k++) drive(10'h100, 1'b0, 8'h00, CD0, 1'b0);
    repeat (3) @(negedge vga_clk);
    chk("slip_count", pulses.size(), 2);
    if (pulses.size() >= 1) chk("slip_first", pulses[0] - rel, T_SEARCH);
    if (pulses.size() >= 2) chk("slip_second", pulses[1] - rel, 2 * T_SEARCH + 1 + T_WAIT);

    do_reset();
    acquire_lock();
    drive(10'h0AB, 1'b1, 8'h00, CD0, 1'b0);
    for (int k = 0; k < 3; k++) drive(10'h3FF, 1'b1, 8'h00, 1'b1, DISP_ON && k == 2);
    drive(10'h355, 1'b1, 8'h00, CD0, 1'b0);
    drive(10'h200, 1'b1, 8'hFF, CD0, 1'b0);
    drive(10'h200, 1'b1, 8'hFF, CD0, 1'b0);
    @(posedge vga_clk);
    #2;
    chk("pre_rst_aligned", int'(aligned), 1);
    exp_q.delete();
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_data", int'(data_out), 0);
    chk("mid_rst_hsync", int'(hsync), 0);
    chk("mid_rst_vsync", int'(vsync), 0);
    chk("mid_rst_de", int'(de), 0);
    chk("mid_rst_bitslip", int'(bitslip), 0);
    chk("mid_rst_aligned", int'(aligned), 0);
    chk("mid_rst_disp_err", int'(disp_err), 0);
    repeat (2) @(negedge vga_clk);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge vga_clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
